tm1638_frame_driver: RTL and testbench
======================================

Name: tm1638_frame_driver

Overview:
Parametrised TM1638 link engine for the digital-clock display path. It accepts a full display frame (segment bytes, LED bits, brightness) and serialises the TM1638 command sequence on stb/sclk/dio. Optionally it reads back the 32-bit key-scan word. It sits between the BCD-to-segment stage and the board pins, replacing fixed-width, write-only display driving.

Parameters:
NUM_DIGITS, 8, digits driven (1..8); any other value is an elaboration error
CLK_DIV, 25, clk_50M cycles per sclk half-period (>=1)
STB_GAP, 50, cycles stb is held high after each command segment (>=1)
READ_WAIT, 50, cycles between the read command's last bit and the first read bit (>=1)

Ports:
clk_50M  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request one frame; accepted only when busy=0
seg_data  in  8*NUM_DIGITS  segment byte k at [8k+7:8k]
led  in  NUM_DIGITS  LED k on/off
brightness  in  3  pulse-width code
disp_on  in  1  display enable
key_scan_en  in  1  append a key-read segment to this frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end
keys  out  32  last key-scan word, byte0 in [7:0]
keys_valid  out  1  one-cycle pulse with done when keys was updated
stb  out  1  TM1638 STB
sclk  out  1  TM1638 CLK
dio_out  out  1  DIO drive value
dio_oe  out  1  DIO drive enable (1 = drive)
dio_in  in  1  DIO pin readback

Behaviour:
- Reset: stb=1, sclk=1, dio_out=1, dio_oe=1, busy=0, done=0, keys=0, keys_valid=0, state=IDLE. Reset mid-frame aborts the frame immediately with no done pulse.
- IDLE: on start=1, latch all frame inputs and key_scan_en. busy=1 from the next cycle. Later input changes are ignored. start while busy=1 is ignored, not queued.
- Bit timing: each bit is 2*CLK_DIV cycles, LSB first.
  - Low phase: sclk=0 for CLK_DIV cycles; dio_out is updated on the first cycle of the low phase.
  - High phase: sclk=1 for CLK_DIV cycles.
- Segments: each segment is stb=0 for the whole segment, then stb=1 for STB_GAP cycles.
  - S1: byte 0x40 (write, auto-increment).
  - S2: byte 0xC0, then 16 data bytes. For k<NUM_DIGITS, address 2k = seg_data byte k and address 2k+1 = {7'b0, led[k]}. Addresses for k>=NUM_DIGITS are 0x00.
  - S3: byte 0x80 | disp_on<<3 | brightness.
  - S4 (only if key_scan_en was latched):
    - Send byte 0x42.
    - dio_oe=0 from the cycle after the last bit through the end of S4.
    - sclk=1 for READ_WAIT cycles, then 32 read bits.
    - dio_in is sampled on the last cycle of each high phase; bit i goes to keys[i].
- Frame length from the first busy cycle:
  - Write-only: T = 152*2*CLK_DIV + 3*STB_GAP.
  - With scan: T + 8*2*CLK_DIV + READ_WAIT + 32*2*CLK_DIV + STB_GAP.
- End of frame:
  - busy is high for exactly that many cycles. On the next cycle busy=0 and done=1.
  - keys updates and keys_valid=1 on that same cycle, scan frames only.
  - dio_oe returns to 1 and dio_out to 1.
- Back-to-back: start asserted in the done cycle is accepted.
- Counters: divider width is $clog2(CLK_DIV+1) and wraps only under FSM control. The bit counter spans 0..7 and the byte counter 0..16.
- FSM states: IDLE, SEND_BITS, GAP, READ_WAIT, READ_BITS, DONE.

Decomposition:
- Shared package tm1638_pkg:
  - Constants: CMD_WRITE_AUTO=8'h40, CMD_READ_KEYS=8'h42, CMD_ADDR0=8'hC0, CMD_DISP=8'h80, NUM_ADDR=16.
  - FSM state encoding.
- One sub-module, tm1638_bit_engine: CLK_DIV phase generator plus 8-bit shift-out/shift-in with a byte_done pulse. The top FSM sequences bytes and segments.

Test Plan:
- Full write frame: NUM_DIGITS=8, CLK_DIV=2, STB_GAP=4, digits 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07, led=8'hA5, brightness=7, disp_on=1 -> decoded bytes 0x40 | 0xC0,0x3F,0x01,0x06,0x00,0x5B,0x01,... | 0x8F; busy exactly 620 cycles; single done pulse.
- Reduced width: NUM_DIGITS=4 -> addresses 8..15 carry 0x00; disp_on=0, brightness=3 -> S3 byte 0x83.
- Key scan: key_scan_en=1, bench drives dio_in for 0x12345678 LSB first -> dio_oe=0 only inside S4 after the 0x42 byte; keys=32'h12345678 with keys_valid coincident with done.
- start pulsed every cycle while busy -> exactly one frame; inputs changed mid-frame do not appear on dio.
- Reset asserted mid-S2 -> next cycle stb=1, sclk=1, dio_oe=1, busy=0, no done; the following start produces a complete, correct frame.
- Start held high through done -> second frame starts with busy rising on the cycle after done, no idle gap.

Source files
------------

// File: rtl/tm1638_pkg.sv
// tm1638_pkg
// Shared definitions for the TM1638 frame driver: command bytes, address
// count, and the state / segment encodings used by the sequencing FSM.
package tm1638_pkg;

    localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;  // data write, auto-increment address
    localparam logic [7:0] CMD_READ_KEYS  = 8'h42;  // key-scan read
    localparam logic [7:0] CMD_ADDR0      = 8'hC0;  // set address 0
    localparam logic [7:0] CMD_DISP       = 8'h80;  // display control base
    localparam int         NUM_ADDR       = 16;     // display RAM bytes written per frame

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_BITS,
        ST_GAP,
        ST_READ_WAIT,
        ST_READ_BITS,
        ST_DONE
    } state_t;

    // Command segment currently in flight (each ends with an stb-high gap).
    typedef enum logic [1:0] {
        SEG_MODE,   // S1: write-mode command
        SEG_DATA,   // S2: address command + 16 data bytes
        SEG_DISP,   // S3: display control
        SEG_KEYS    // S4: key-scan read
    } seg_t;

endpackage

// File: rtl/tm1638_bit_engine.sv
// tm1638_bit_engine
// Serial bit engine: generates the sclk low/high phases (CLK_DIV cycles
// each) and shifts one byte out LSB first while shifting dio_in in.
//   load/load_byte : restart at a byte boundary with a new transmit byte
//   run            : advance the phase generator
//   sclk, dio_bit  : serial clock and current transmit bit
//   byte_done      : pulse on the last cycle of the 8th bit
//   rx_byte        : received byte, valid together with byte_done
module tm1638_bit_engine #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       run,
    input  logic       dio_in,
    output logic       sclk,
    output logic       dio_bit,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    localparam int                DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic             phase_reg;     // 0 = sclk low phase, 1 = sclk high phase
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             half_end;

    assign half_end  = run && (div_cnt_reg == DIV_LAST);
    assign byte_done = half_end && phase_reg && (bit_cnt_reg == 3'd7);
    assign sclk      = phase_reg;
    assign dio_bit   = shift_reg[0];
    // Includes the bit being sampled this cycle so the byte is complete
    // at byte_done.
    assign rx_byte   = {dio_in, shift_reg[7:1]};

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            div_cnt_reg <= '0;
            phase_reg   <= 1'b0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else if (load) begin
            div_cnt_reg <= '0;
            phase_reg   <= 1'b0;
            bit_cnt_reg <= '0;
            shift_reg   <= load_byte;
        end else if (run) begin
            if (half_end) begin
                div_cnt_reg <= '0;
                phase_reg   <= ~phase_reg;
                // End of the high phase: sample dio_in and expose the next
                // transmit bit for the following low phase.
                if (phase_reg) begin
                    shift_reg   <= {dio_in, shift_reg[7:1]};
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/tm1638_frame_driver.sv
// tm1638_frame_driver
// Sends one complete TM1638 display frame per start request: write-mode
// command, address command + 16 data bytes, display control, and
// optionally a key-scan read returning a 32-bit key word.
//   clk_50M, reset          : clock, synchronous active-high reset
//   start                   : frame request (taken only when not busy)
//   seg_data, led           : per-digit segment bytes and LED bits
//   brightness, disp_on     : display control fields
//   key_scan_en             : append a key-scan read to this frame
//   busy, done              : frame in progress / end-of-frame pulse
//   keys, keys_valid        : last key word and its update pulse
//   stb, sclk, dio_out,
//   dio_oe, dio_in          : TM1638 pins (dio_oe=1 drives DIO)
module tm1638_frame_driver
    import tm1638_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 25,
    parameter int STB_GAP    = 50,
    parameter int READ_WAIT  = 50
) (
    input  logic                    clk_50M,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*NUM_DIGITS-1:0] seg_data,
    input  logic [NUM_DIGITS-1:0]   led,
    input  logic [2:0]              brightness,
    input  logic                    disp_on,
    input  logic                    key_scan_en,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             keys,
    output logic                    keys_valid,
    output logic                    stb,
    output logic                    sclk,
    output logic                    dio_out,
    output logic                    dio_oe,
    input  logic                    dio_in
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("tm1638_frame_driver: NUM_DIGITS must be in 1..8");
    end

    localparam int               WAIT_MAX = (STB_GAP > READ_WAIT) ? STB_GAP : READ_WAIT;
    localparam int               CNT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STB_GAP - 1);
    localparam logic [CNT_W-1:0] RW_LAST  = CNT_W'(READ_WAIT - 1);

    state_t                  state_reg, state_next;
    seg_t                    seg_reg, seg_next;
    logic [4:0]              byte_cnt_reg, byte_cnt_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [8*NUM_DIGITS-1:0] seg_data_reg;
    logic [NUM_DIGITS-1:0]   led_reg;
    logic [2:0]              brightness_reg;
    logic                    disp_on_reg;
    logic                    scan_reg;
    logic [31:0]             keys_acc_reg;
    logic [31:0]             keys_reg;

    logic       capture, load, keys_upd;
    logic [7:0] tx_byte;
    logic [3:0] addr_idx;
    logic       eng_run, eng_sclk, eng_dio, eng_byte_done;
    logic [7:0] eng_rx_byte;

    // Display RAM image: even address = segments, odd address = LED bit;
    // digits beyond NUM_DIGITS are blanked.
    logic [7:0] addr_bytes [NUM_ADDR];

    for (genvar gi = 0; gi < NUM_ADDR / 2; gi++) begin : g_addr
        if (gi < NUM_DIGITS) begin : g_used
            assign addr_bytes[2*gi]   = seg_data_reg[8*gi +: 8];
            assign addr_bytes[2*gi+1] = {7'b0, led_reg[gi]};
        end else begin : g_blank
            assign addr_bytes[2*gi]   = 8'h00;
            assign addr_bytes[2*gi+1] = 8'h00;
        end
    end

    assign eng_run = (state_reg == ST_SEND_BITS) || (state_reg == ST_READ_BITS);
    assign keys    = keys_reg;

    tm1638_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_engine (
        .clk_50M   (clk_50M),
        .reset     (reset),
        .load      (load),
        .load_byte (tx_byte),
        .run       (eng_run),
        .dio_in    (dio_in),
        .sclk      (eng_sclk),
        .dio_bit   (eng_dio),
        .byte_done (eng_byte_done),
        .rx_byte   (eng_rx_byte)
    );

    always_ff @(posedge clk_50M) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        seg_next      = seg_reg;
        byte_cnt_next = byte_cnt_reg;
        cnt_next      = cnt_reg;
        capture       = 1'b0;
        load          = 1'b0;
        keys_upd      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        keys_valid    = 1'b0;
        stb           = 1'b1;
        sclk          = 1'b1;
        dio_out       = 1'b1;
        dio_oe        = 1'b1;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                done       = (state_reg == ST_DONE);
                keys_valid = (state_reg == ST_DONE) && scan_reg;
                state_next = ST_IDLE;
                // Also taken in the DONE cycle, so back-to-back frames
                // have no idle gap.
                if (start) begin
                    capture       = 1'b1;
                    load          = 1'b1;
                    seg_next      = SEG_MODE;
                    byte_cnt_next = '0;
                    state_next    = ST_SEND_BITS;
                end
            end
            ST_SEND_BITS: begin
                busy    = 1'b1;
                stb     = 1'b0;
                sclk    = eng_sclk;
                dio_out = eng_dio;
                if (eng_byte_done) begin
                    cnt_next = '0;
                    if (seg_reg == SEG_DATA && byte_cnt_reg < 5'(NUM_ADDR)) begin
                        byte_cnt_next = byte_cnt_reg + 5'd1;
                        load          = 1'b1;
                    end else if (seg_reg == SEG_KEYS) begin
                        state_next = ST_READ_WAIT;
                    end else begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                busy   = 1'b1;
                // The bus stays released through the key segment's gap.
                dio_oe = (seg_reg != SEG_KEYS);
                if (cnt_reg == GAP_LAST) begin
                    cnt_next      = '0;
                    byte_cnt_next = '0;
                    state_next    = ST_SEND_BITS;
                    case (seg_reg)
                        SEG_MODE: begin
                            seg_next = SEG_DATA;
                            load     = 1'b1;
                        end
                        SEG_DATA: begin
                            seg_next = SEG_DISP;
                            load     = 1'b1;
                        end
                        SEG_DISP: begin
                            if (scan_reg) begin
                                seg_next = SEG_KEYS;
                                load     = 1'b1;
                            end else begin
                                state_next = ST_DONE;
                            end
                        end
                        default: begin
                            keys_upd   = 1'b1;
                            state_next = ST_DONE;
                        end
                    endcase
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_READ_WAIT: begin
                busy   = 1'b1;
                stb    = 1'b0;
                dio_oe = 1'b0;
                if (cnt_reg == RW_LAST) begin
                    cnt_next      = '0;
                    byte_cnt_next = '0;
                    load          = 1'b1;
                    state_next    = ST_READ_BITS;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_READ_BITS: begin
                busy   = 1'b1;
                stb    = 1'b0;
                dio_oe = 1'b0;
                sclk   = eng_sclk;
                if (eng_byte_done) begin
                    if (byte_cnt_reg == 5'd3) begin
                        cnt_next   = '0;
                        state_next = ST_GAP;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 5'd1;
                        load          = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Byte to load for the segment/byte position being entered.
    always_comb begin
        addr_idx = 4'(byte_cnt_next - 5'd1);
        case (seg_next)
            SEG_MODE: tx_byte = CMD_WRITE_AUTO;
            SEG_DATA: tx_byte = (byte_cnt_next == 5'd0) ? CMD_ADDR0 : addr_bytes[addr_idx];
            SEG_DISP: tx_byte = CMD_DISP | {4'b0, disp_on_reg, brightness_reg};
            default:  tx_byte = CMD_READ_KEYS;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            seg_reg        <= SEG_MODE;
            byte_cnt_reg   <= '0;
            cnt_reg        <= '0;
            seg_data_reg   <= '0;
            led_reg        <= '0;
            brightness_reg <= '0;
            disp_on_reg    <= 1'b0;
            scan_reg       <= 1'b0;
            keys_acc_reg   <= '0;
            keys_reg       <= '0;
        end else begin
            seg_reg      <= seg_next;
            byte_cnt_reg <= byte_cnt_next;
            cnt_reg      <= cnt_next;
            if (capture) begin
                seg_data_reg   <= seg_data;
                led_reg        <= led;
                brightness_reg <= brightness;
                disp_on_reg    <= disp_on;
                scan_reg       <= key_scan_en;
            end
            // Key bytes arrive byte0 first; shifting down leaves byte0 in [7:0].
            if (state_reg == ST_READ_BITS && eng_byte_done)
                keys_acc_reg <= {eng_rx_byte, keys_acc_reg[31:8]};
            if (keys_upd)
                keys_reg <= keys_acc_reg;
        end
    end

endmodule

// File: tb/tb_tm1638_frame_driver.sv
module tb_tm1638_frame_driver;

    localparam int CD   = 2;
    localparam int SG   = 4;
    localparam int RW   = 6;
    localparam int T_WR = 152*2*CD + 3*SG;                       // 620
    localparam int T_SC = T_WR + 8*2*CD + RW + 32*2*CD + SG;     // 790

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] seg_data = '0;
    logic [7:0]  led = '0;
    logic [2:0]  brightness = '0;
    logic        disp_on = 1'b0;
    logic        key_scan_en = 1'b0;
    logic        dio_in = 1'b1;

    logic        busy8, done8, kv8, stb8, sclk8, dout8, doe8;
    logic [31:0] keys8;
    logic        busy4, done4, kv4, stb4, sclk4, dout4, doe4;
    logic [31:0] keys4;

    bit          sel = 1'b0;   // 0 = observe 8-digit instance, 1 = 4-digit instance
    logic        m_busy, m_done, m_kv, m_stb, m_sclk, m_dout, m_doe;
    logic [31:0] m_keys;

    always #5 clk = ~clk;

    tm1638_frame_driver #(.NUM_DIGITS(8), .CLK_DIV(CD), .STB_GAP(SG), .READ_WAIT(RW)) dut (
        .clk_50M(clk), .reset(reset), .start(start), .seg_data(seg_data), .led(led),
        .brightness(brightness), .disp_on(disp_on), .key_scan_en(key_scan_en),
        .busy(busy8), .done(done8), .keys(keys8), .keys_valid(kv8), .stb(stb8),
        .sclk(sclk8), .dio_out(dout8), .dio_oe(doe8), .dio_in(dio_in));

    tm1638_frame_driver #(.NUM_DIGITS(4), .CLK_DIV(CD), .STB_GAP(SG), .READ_WAIT(RW)) dut4 (
        .clk_50M(clk), .reset(reset), .start(start), .seg_data(seg_data[31:0]), .led(led[3:0]),
        .brightness(brightness), .disp_on(disp_on), .key_scan_en(key_scan_en),
        .busy(busy4), .done(done4), .keys(keys4), .keys_valid(kv4), .stb(stb4),
        .sclk(sclk4), .dio_out(dout4), .dio_oe(doe4), .dio_in(dio_in));

    assign m_busy = sel ? busy4 : busy8;
    assign m_done = sel ? done4 : done8;
    assign m_kv   = sel ? kv4   : kv8;
    assign m_keys = sel ? keys4 : keys8;
    assign m_stb  = sel ? stb4  : stb8;
    assign m_sclk = sel ? sclk4 : sclk8;
    assign m_dout = sel ? dout4 : dout8;
    assign m_doe  = sel ? doe4  : doe8;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int total = 0;
    int bad   = 0;

    // Pin monitor: decodes written bytes, plays the key-scan word back on
    // dio_in, and counts done pulses / where the bus was released.
    int          done_total = 0;
    int          obs_total  = 0;
    int          oe_fall_at = -1;
    int          mon_bits   = 0;
    int          rd_cnt     = 0;
    logic [7:0]  mon_shift  = '0;
    logic        prev_sclk  = 1'b1;
    logic        prev_doe   = 1'b1;
    logic [31:0] key_word   = 32'h12345678;

    always @(negedge clk) begin
        if (m_done) done_total++;
        if (!m_doe && prev_doe) oe_fall_at = obs_total;
        if (m_doe) rd_cnt = 0;
        else if (prev_sclk && !m_sclk) begin
            dio_in = key_word[rd_cnt];
            rd_cnt = (rd_cnt + 1) % 32;
        end
        if (m_stb) mon_bits = 0;
        else if (!prev_sclk && m_sclk && m_doe) begin
            mon_shift = {m_dout, mon_shift[7:1]};
            mon_bits++;
            if (mon_bits == 8) begin
                obs_q.push_back(mon_shift);
                obs_total++;
                mon_bits = 0;
            end
        end
        prev_sclk = m_sclk;
        prev_doe  = m_doe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [63:0] sd, input logic [7:0] ld, input logic [2:0] br,
                              input logic dn, input logic sc);
        seg_data = sd; led = ld; brightness = br; disp_on = dn; key_scan_en = sc;
    endtask

    // Expected byte stream for the current inputs on an nd-digit instance.
    task automatic push_frame(input int nd);
        int k;
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hC0);
        for (int a = 0; a < 16; a++) begin
            k = a / 2;
            if (k >= nd)         exp_q.push_back(8'h00);
            else if (a % 2 == 0) exp_q.push_back(seg_data[8*k +: 8]);
            else                 exp_q.push_back({7'b0, led[k]});
        end
        exp_q.push_back(8'h80 | {4'b0, disp_on, brightness});
        if (key_scan_en) exp_q.push_back(8'h42);
    endtask

    task automatic drain(input string tag);
        logic [7:0] o, e;
        int i;
        check({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        i = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check($sformatf("%s_byte%0d", tag, i), o, e);
            i++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic launch(input bit hold);
        start = 1'b1;
        @(negedge clk);
        start = hold;
    endtask

    // Called on the first busy cycle; counts busy cycles and checks the end.
    task automatic finish_frame(input int exp_len, input bit spam, input bit hold,
                                input bit scan, input string tag);
        int n, d0;
        d0 = done_total;
        n  = 0;
        while (m_busy && n < 5000) begin
            n++;
            if (spam) begin
                if (n == 50) set_inputs(~seg_data, ~led, ~brightness, ~disp_on, 1'b0);
                if (n >= exp_len - 5) start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_busy_len"}, n, exp_len);
        check({tag, "_done"}, m_done, 1'b1);
        check({tag, "_doe_end"}, m_doe, 1'b1);
        check({tag, "_dout_end"}, m_dout, 1'b1);
        check({tag, "_stb_end"}, m_stb, 1'b1);
        check({tag, "_kvalid"}, m_kv, scan);
        if (scan) check({tag, "_keys"}, m_keys, 32'h12345678);
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
            check({tag, "_done_1cyc"}, m_done, 1'b0);
            check({tag, "_kvalid_1cyc"}, m_kv, 1'b0);
            repeat (6) @(negedge clk);
            check({tag, "_done_count"}, done_total - d0, 1);
            check({tag, "_idle_busy"}, m_busy, 1'b0);
            drain(tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, d0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_stb", m_stb, 1'b1);
        check("rst_sclk", m_sclk, 1'b1);
        check("rst_dout", m_dout, 1'b1);
        check("rst_doe", m_doe, 1'b1);
        check("rst_busy", m_busy, 1'b0);
        check("rst_done", m_done, 1'b0);
        check("rst_keys", m_keys, 32'h0);
        check("rst_kv", m_kv, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full 8-digit write frame
        set_inputs(64'h077D6D664F5B063F, 8'hA5, 3'd7, 1'b1, 1'b0);
        push_frame(8);
        launch(1'b0);
        finish_frame(T_WR, 1'b0, 1'b0, 1'b0, "wr8");

        // Reduced width instance, display off
        sel = 1'b1;
        set_inputs(64'hFFFFFFFF_4F5B063F, 8'hF6, 3'd3, 1'b0, 1'b0);
        push_frame(4);
        launch(1'b0);
        finish_frame(T_WR, 1'b0, 1'b0, 1'b0, "wr4");
        sel = 1'b0;
        repeat (2) @(negedge clk);

        // Key-scan frame
        set_inputs(64'h0123456789ABCDEF, 8'h3C, 3'd2, 1'b1, 1'b1);
        push_frame(8);
        o0 = obs_total;
        launch(1'b0);
        finish_frame(T_SC, 1'b0, 1'b0, 1'b1, "scan");
        check("scan_oe_release_after_byte", oe_fall_at - o0, 20);

        // start held through the frame, inputs changed mid-frame
        set_inputs(64'h1122334455667788, 8'h5A, 3'd5, 1'b1, 1'b0);
        push_frame(8);
        launch(1'b1);
        finish_frame(T_WR, 1'b1, 1'b0, 1'b0, "spam");

        // Reset in the middle of the data segment
        set_inputs(64'hDEADBEEFCAFEF00D, 8'h81, 3'd1, 1'b1, 1'b0);
        push_frame(8);
        d0 = done_total;
        launch(1'b0);
        repeat (59) @(negedge clk);
        check("mid_busy_pre", m_busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_stb", m_stb, 1'b1);
        check("mid_rst_sclk", m_sclk, 1'b1);
        check("mid_rst_doe", m_doe, 1'b1);
        check("mid_rst_busy", m_busy, 1'b0);
        check("mid_rst_done", m_done, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_no_done", done_total - d0, 0);
        obs_q.delete();
        exp_q.delete();
        set_inputs(64'h6F7F077D6D664F5B, 8'h0F, 3'd4, 1'b1, 1'b0);
        push_frame(8);
        launch(1'b0);
        finish_frame(T_WR, 1'b0, 1'b0, 1'b0, "post_rst");

        // Back-to-back frames with start held through done
        set_inputs(64'h3F065B4F666D7D07, 8'hC3, 3'd6, 1'b1, 1'b0);
        push_frame(8);
        push_frame(8);
        launch(1'b1);
        finish_frame(T_WR, 1'b0, 1'b1, 1'b0, "b2b_first");
        @(negedge clk);
        check("b2b_no_gap_busy", m_busy, 1'b1);
        check("b2b_no_gap_stb", m_stb, 1'b0);
        start = 1'b0;
        finish_frame(T_WR, 1'b0, 1'b0, 1'b0, "b2b_second");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
